// File: rtl/ex_result_fifo_if.sv
// rtl/ex_result_fifo_if.sv - pipeline result beat in, buffered result handshake out
interface ex_result_fifo_if #(
    parameter int OUTPUT_WIDTH = 16
) ();
    logic                    valid_out_interface;
    logic                    arctan_en_out_interface;
    logic [OUTPUT_WIDTH-1:0] degree_out_interface;
    logic [OUTPUT_WIDTH-1:0] x_out_interface;
    logic [OUTPUT_WIDTH-1:0] y_out_interface;

    logic                    res_valid;
    logic                    res_ready;
    logic                    res_arctan_en;
    logic [OUTPUT_WIDTH-1:0] res_degree;
    logic [OUTPUT_WIDTH-1:0] res_x;
    logic [OUTPUT_WIDTH-1:0] res_y;

    modport master (
        output valid_out_interface, arctan_en_out_interface,
        output degree_out_interface, x_out_interface, y_out_interface,
        output res_ready,
        input  res_valid, res_arctan_en, res_degree, res_x, res_y
    );

    modport slave (
        input  valid_out_interface, arctan_en_out_interface,
        input  degree_out_interface, x_out_interface, y_out_interface,
        input  res_ready,
        output res_valid, res_arctan_en, res_degree, res_x, res_y
    );
endinterface

// File: rtl/ex_result_fifo.sv
// rtl/ex_result_fifo.sv - FWFT result buffer with in-flight credit accounting
module ex_result_fifo #(
    parameter int OUTPUT_WIDTH = 16,
    parameter int DEPTH        = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    ex_result_fifo_if.slave      bus,
    input  logic                 issue_in,
    output logic                 credit_ok,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] inflight,
    output logic                 overflow,
    output logic                 credit_err
);
    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int ENTRY_WIDTH = 3 * OUTPUT_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH:0]   DEPTH_WC = (CNT_WIDTH + 1)'(DEPTH);

    logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d, inflight_q, inflight_d;
    logic                   overflow_q, overflow_d, credit_err_q, credit_err_d;
    logic [CNT_WIDTH:0]     committed;
    logic                   head_valid, full, beat, pop, push;
    logic [ENTRY_WIDTH-1:0] head;

    assign head_valid = (count_q != '0);
    assign full       = (count_q == DEPTH_C);
    assign beat       = bus.valid_out_interface;
    assign pop        = head_valid && bus.res_ready;
    // A full buffer still accepts a beat when the head leaves in the same cycle.
    assign push       = beat && (!full || pop);

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + PTR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_WIDTH'(1) : rd_ptr_q;
        count_d      = count_q;
        inflight_d   = inflight_q;
        overflow_d   = overflow_q | (beat && !push);
        credit_err_d = credit_err_q | (issue_in && !credit_ok) | (beat && inflight_q == '0);

        if (push && !pop) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_WIDTH'(1);
        end

        if (issue_in && !beat) begin
            if (inflight_q != CNT_MAX) inflight_d = inflight_q + CNT_WIDTH'(1);
        end else if (beat && !issue_in) begin
            if (inflight_q != '0) inflight_d = inflight_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= '0;
            overflow_q   <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            overflow_q   <= overflow_d;
            credit_err_q <= credit_err_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= {bus.arctan_en_out_interface, bus.degree_out_interface,
                                bus.x_out_interface, bus.y_out_interface};
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.res_valid = head_valid;
    assign {bus.res_arctan_en, bus.res_degree, bus.res_x, bus.res_y} =
        head_valid ? head : '0;

    assign committed  = {1'b0, count_q} + {1'b0, inflight_q};
    assign credit_ok  = (committed < DEPTH_WC);
    assign count      = count_q;
    assign inflight   = inflight_q;
    assign overflow   = overflow_q;
    assign credit_err = credit_err_q;
endmodule

// File: tb/tb_ex_result_fifo.sv
// tb/tb_ex_result_fifo.sv - directed self-checking bench for ex_result_fifo
module tb_ex_result_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic       issue_in;
    logic       credit_ok;
    logic [3:0] count;
    logic [3:0] inflight;
    logic       overflow;
    logic       credit_err;
    int         checks = 0;
    int         errors = 0;
    logic [15:0] exp_q[$];

    ex_result_fifo_if #(.OUTPUT_WIDTH(16)) bus ();

    ex_result_fifo #(.OUTPUT_WIDTH(16), .DEPTH(8), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .bus(bus), .issue_in(issue_in),
        .credit_ok(credit_ok), .count(count), .inflight(inflight),
        .overflow(overflow), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [15:0] d, input logic [15:0] x, input logic [15:0] y, input logic a);
        bus.valid_out_interface     = 1'b1;
        bus.degree_out_interface    = d;
        bus.x_out_interface         = x;
        bus.y_out_interface         = y;
        bus.arctan_en_out_interface = a;
    endtask

    task automatic clr_beat();
        bus.valid_out_interface     = 1'b0;
        bus.degree_out_interface    = '0;
        bus.x_out_interface         = '0;
        bus.y_out_interface         = '0;
        bus.arctan_en_out_interface = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        issue_in = 1'b0;
        bus.res_ready = 1'b0;
        clr_beat();
        step();
        step();
        check("rst_valid", bus.res_valid, 0);
        check("rst_count", count, 0);
        check("rst_inflight", inflight, 0);
        check("rst_overflow", overflow, 0);
        check("rst_credit_err", credit_err, 0);
        check("rst_credit_ok", credit_ok, 1);
        check("rst_degree", bus.res_degree, 0);
        reset = 1'b0;

        // single request round trip
        issue_in = 1'b1;
        step();
        issue_in = 1'b0;
        check("t1_inflight", inflight, 1);
        for (int i = 0; i < 7; i++) step();
        set_beat(16'h1A00, 16'h0100, 16'h0080, 1'b1);
        step();
        clr_beat();
        check("t1_valid", bus.res_valid, 1);
        check("t1_degree", bus.res_degree, 32'h1A00);
        check("t1_x", bus.res_x, 32'h0100);
        check("t1_y", bus.res_y, 32'h0080);
        check("t1_arctan", bus.res_arctan_en, 1);
        check("t1_count", count, 1);
        check("t1_inflight0", inflight, 0);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("t1_pop_count", count, 0);
        check("t1_pop_valid", bus.res_valid, 0);
        check("t1_pop_degree", bus.res_degree, 0);

        // eight issues back to back, then fill
        for (int i = 0; i < 8; i++) begin
            check("t2_credit_before", credit_ok, 1);
            issue_in = 1'b1;
            step();
        end
        issue_in = 1'b0;
        check("t2_inflight8", inflight, 8);
        check("t2_credit_off", credit_ok, 0);
        for (int i = 0; i < 8; i++) begin
            set_beat(16'h0010 + 16'(i), 16'h0020 + 16'(i), 16'h0030 + 16'(i), i[0]);
            exp_q.push_back(16'h0010 + 16'(i));
            step();
        end
        clr_beat();
        check("t2_count", count, 8);
        check("t2_inflight", inflight, 0);
        check("t2_overflow", overflow, 0);
        check("t2_credit_err", credit_err, 0);
        check("t2_credit_ok", credit_ok, 0);
        check("t2_head", bus.res_degree, 32'h0010);

        // beat while full, no pop
        set_beat(16'h7777, 16'h7777, 16'h7777, 1'b1);
        step();
        clr_beat();
        check("t3_overflow", overflow, 1);
        check("t3_count", count, 8);
        check("t3_head", bus.res_degree, 32'h0010);
        check("t3_head_x", bus.res_x, 32'h0020);
        check("t3_credit_err", credit_err, 1);

        // full-throughput streaming at count==DEPTH across pointer wrap
        bus.res_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check("t4_head", bus.res_degree, 32'(exp_q[0]));
            set_beat(16'h0100 + 16'(k), 16'h0200 + 16'(k), 16'h0300 + 16'(k), 1'b0);
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(16'h0100 + 16'(k));
        end
        clr_beat();
        check("t4_count", count, 8);
        for (int k = 0; k < 8; k++) begin
            check("t4_drain", bus.res_degree, 32'(exp_q[0]));
            step();
            void'(exp_q.pop_front());
        end
        bus.res_ready = 1'b0;
        check("t4_empty", bus.res_valid, 0);
        check("t4_count0", count, 0);

        // unsolicited beat into an empty buffer
        do_reset();
        check("t5_err_clear", credit_err, 0);
        set_beat(16'h0AAA, 16'h0BBB, 16'h0CCC, 1'b0);
        step();
        clr_beat();
        check("t5_count", count, 1);
        check("t5_degree", bus.res_degree, 32'h0AAA);
        check("t5_credit_err", credit_err, 1);
        check("t5_inflight", inflight, 0);
        check("t5_overflow", overflow, 0);

        // reset with count=5 inflight=3, beat and issue present during reset
        do_reset();
        issue_in = 1'b1;
        for (int i = 0; i < 8; i++) step();
        issue_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_beat(16'h0040 + 16'(i), 16'h0, 16'h0, 1'b0);
            step();
        end
        clr_beat();
        check("t6_count5", count, 5);
        check("t6_inflight3", inflight, 3);
        check("t6_credit_ok0", credit_ok, 0);
        reset = 1'b1;
        issue_in = 1'b1;
        set_beat(16'h5555, 16'h5555, 16'h5555, 1'b1);
        step();
        reset = 1'b0;
        issue_in = 1'b0;
        clr_beat();
        check("t6_valid", bus.res_valid, 0);
        check("t6_count", count, 0);
        check("t6_inflight", inflight, 0);
        check("t6_overflow", overflow, 0);
        check("t6_credit_err", credit_err, 0);
        check("t6_credit_ok", credit_ok, 1);
        check("t6_degree", bus.res_degree, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_result_fifo.md
# ex_result_fifo

Result buffer sitting directly downstream of the CORDIC execution top. Captures each valid result beat (degree, x, y, arctan mode flag) from the execution pipeline's output interface, which has no backpressure, into a first-word-fall-through FIFO, and presents it to the consumer over a valid/ready handshake. It also tracks requests in flight inside the pipeline and issues a credit signal so the upstream issuer never launches a request whose result could not be stored.

## Interface
- OUTPUT_WIDTH, 16: width of each result field (signed Q7.8).
- DEPTH, 8: FIFO entries; power of two, at least 2.
- CNT_WIDTH, 4: width of occupancy and in-flight counters; must be at least $clog2(DEPTH+1).

- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_in  in  1  high for one cycle per request launched into the pipeline; same cycle as the pipeline's input valid.
- credit_ok  out  1  upstream may assert issue_in this cycle.
- valid_out_interface  in  1  pipeline result beat valid.
- arctan_en_out_interface  in  1  mode flag of the result beat.
- degree_out_interface  in  OUTPUT_WIDTH  signed angle result.
- x_out_interface  in  OUTPUT_WIDTH  signed x result.
- y_out_interface  in  OUTPUT_WIDTH  signed y result.
- res_valid  out  1  head entry available.
- res_ready  in  1  consumer accepts the head entry.
- res_arctan_en  out  1  head entry mode flag.
- res_degree, res_x, res_y  out  OUTPUT_WIDTH each  head entry fields.
- count  out  CNT_WIDTH  entries stored.
- inflight  out  CNT_WIDTH  issued requests whose results have not yet arrived.
- overflow  out  1  sticky: a result beat was dropped.
- credit_err  out  1  sticky: issue_in while credit_ok=0, or a result beat arrived with inflight=0.

## Operation
- Storage is a DEPTH-entry circular buffer holding {arctan_en, degree, x, y}, with wr_ptr and rd_ptr that wrap modulo DEPTH.
- Write: on valid_out_interface, the beat is stored at wr_ptr when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle. Otherwise the beat is dropped and overflow is set.
- Pop: occurs when res_valid && res_ready. rd_ptr advances by one.
- Occupancy: count +1 on write only, -1 on pop only, unchanged on both or neither.
- res_valid = (count != 0). res_* data fields are driven from mem[rd_ptr] when res_valid=1 and are 0 otherwise.
- inflight: +1 on issue_in, -1 on valid_out_interface, unchanged when both or neither occur. It saturates at 0: a decrement at 0 leaves it at 0 and sets credit_err. It saturates at 2^CNT_WIDTH-1.
- credit_ok = (count + inflight) < DEPTH, combinational from registered state only; no combinational path from issue_in.
- issue_in with credit_ok=0 sets credit_err and is still counted.
- Sticky flags clear only on reset.
- No combinational path from any input to res_valid. res_ready has no effect on res_valid in the same cycle.

## Timing
- Reset (synchronous, active-high): pointers, count and inflight go to 0; overflow and credit_err go to 0; res_valid=0 and all res_* data outputs 0; credit_ok=1 in the first cycle after reset.
- Reset mid-operation discards all stored entries and in-flight accounting. Beats arriving while reset is high are ignored.
- Latency: a beat written at edge N appears with res_valid=1 in the cycle following edge N.
- A pop at edge N exposes the next entry, or res_valid=0, in the following cycle.
- Full throughput: one write and one pop per cycle are sustained indefinitely, including at count==DEPTH.
- Wrap-around: a pointer at DEPTH-1 advances to 0. FIFO ordering is preserved across the wrap.

## Test plan
- Reset, then one issue; 8 cycles later one beat arrives with degree=0x1A00, x=0x0100, y=0x0080, arctan_en=1 -> the next cycle shows res_valid=1 with the same fields; res_ready=1 pops it; count=0; inflight returns 0.
- Issue 8 requests back-to-back with res_ready=0 -> credit_ok drops to 0 after the 8th issue; 8 beats stored; count=8; overflow=0.
- A 9th beat arrives while full with no pop -> beat dropped; overflow=1; the head entry is unchanged; credit_err=1 (inflight was already 0).
- Full FIFO with res_ready=1 and a beat every cycle for 20 cycles -> no drops; output order matches input order; pointers wrap correctly.
- Beat arriving with inflight=0 and an empty FIFO -> stored; credit_err=1; inflight stays 0.
- Reset asserted while count=5 and inflight=3 -> the following cycle shows res_valid=0, count=0, inflight=0, both flags 0, credit_ok=1.
